lpc_host: RTL and testbench
===========================

Name: lpc_host

Overview:
- LPC host (initiator) that issues single-byte I/O / TPM read and write cycles on LCLK/LFRAME/LAD.
- It is the other end of lpc_periph: used as the bench driver for TwPM_Top and as a host-side model for board bring-up.
- Takes one request at a time from a simple req/done interface. Serialises it into LPC nibbles, handles SYNC waits, and returns read data or an error.

Parameters:
- START_NIBBLE, 4'b0101, START field value (0101 = TPM cycle, 0000 = plain I/O).
- SYNC_TIMEOUT, 32, maximum consecutive wait SYNCs (0101/0110) tolerated before abort; minimum 1.
- ABORT_CYCLES, 4, clocks LFRAME is held low during abort; minimum 4.

Ports:
- clk_i, in, 1, LPC clock (LCLK); all logic on the rising edge.
- nrst_i, in, 1, asynchronous active-low reset (LRESET).
- req_i, in, 1, request strobe; accepted only when busy_o=0.
- req_wr_i, in, 1, 1=write, 0=read; sampled with req_i.
- req_addr_i, in, 16, cycle address; sampled with req_i.
- req_data_i, in, 8, write data; sampled with req_i.
- busy_o, out, 1, high from the accept edge until done_o.
- done_o, out, 1, one-cycle completion pulse.
- err_o, out, 1, one-cycle pulse coincident with done_o on error SYNC, invalid SYNC or timeout.
- rd_data_o, out, 8, read data; valid when done_o=1; held until the next read completes.
- lframe_o, out, 1, LFRAME# drive.
- lad_o, out, 4, LAD drive value.
- lad_oe_o, out, 1, LAD output enable; the tristate buffer is resolved at the top or bench level.
- lad_i, in, 4, sampled LAD bus.

Behaviour:
- Reset values:
  - lframe_o=1, lad_o=4'hF, lad_oe_o=0.
  - busy_o=0, done_o=0, err_o=0, rd_data_o=8'h00.
  - State IDLE.
- Reset is asynchronous and mid-cycle: it abandons the transfer immediately, with no abort sequence and no done_o.
- IDLE: when req_i=1, latch wr/addr/data, set busy_o=1 and go to START. req_i is ignored while busy_o=1.
- Fields, one clock each; each item gives the state, then the lframe_o/lad_oe_o/lad_o values it drives:
  - START: lframe_o=0, oe=1, lad_o=START_NIBBLE.
  - CYCTYPE: lframe_o=1, oe=1, lad_o = 4'b0010 for write, 4'b0000 for read.
  - ADDR3..ADDR0: addr[15:12], [11:8], [7:4], [3:0], MSB nibble first.
  - WDATA0/WDATA1 (write only): data[3:0], then data[7:4].
  - TARH0: oe=1, lad_o=4'hF.
  - TARH1: oe=0.
  - SYNC: oe=0; sample lad_i each clock.
    - 0000 → next state.
    - 0101/0110 → stay and increment the wait counter.
    - 1010 → set the error flag, then next state.
    - Any other value → ABORT.
  - RDATA0/RDATA1 (read only): capture lad_i into rd_data[3:0], then [7:4].
  - TARP0, TARP1: oe=0; peripheral turnaround, two clocks, lad_i ignored.
- After TARP1: return to IDLE. In the same transition:
  - done_o=1 and busy_o=0.
  - err_o=error flag.
  - rd_data_o is updated for reads only.
- Latency with zero-wait SYNC (req accept edge to done_o) is exactly 13 clocks for a write and for a read. Each wait SYNC adds 1.
- A next req_i may be asserted in the done_o cycle; it is accepted on that edge.
- Error SYNC on a read still completes the RDATA phase; rd_data_o is updated with whatever was sampled.
- Wait counter: clog2(SYNC_TIMEOUT+1) bits, saturating, cleared on entry to SYNC.
- ABORT:
  - lframe_o=0, oe=1, lad_o=4'hF for ABORT_CYCLES clocks.
  - Then one clock with lframe_o=1, oe=0.
  - Then IDLE, with done_o=1, err_o=1 and rd_data_o unchanged.

Optional Feature:
- Macro LPC_HOST_TIMEOUT_EN.
- Defined: when the wait counter reaches SYNC_TIMEOUT and the current sample is still a wait code, go to ABORT.
- Undefined: the wait counter and timeout are not built; SYNC waits indefinitely. Invalid SYNC codes still abort.

Decomposition:
- Package lpc_pkg, holding:
  - the state enum;
  - START codes (TPM 0101, IO 0000);
  - CYCTYPE codes (IO_RD 0000, IO_WR 0010);
  - SYNC codes (READY 0000, SHORT_WAIT 0101, LONG_WAIT 0110, ERROR 1010).
- The package is shared with lpc_periph in later refactoring.
- No sub-module: one FSM with inline counters; a separate timer would be a thin wrapper.

Test Plan:
- Write: addr 16'h0F00, data 8'hA5, peripheral returns SYNC 0000 on the first clock → LAD sequence 5,2,0,F,0,0,5,A,F,Z; done_o at clock 13, err_o=0.
- Read: addr 16'h0F18, 3×SYNC 0110 then 0000, data nibbles 3,C → done_o at clock 16, rd_data_o=8'hC3, err_o=0.
- Read with SYNC 1010 and data nibbles 0,0 → done_o with err_o=1, rd_data_o=8'h00.
- LPC_HOST_TIMEOUT_EN with SYNC_TIMEOUT=4 and endless 0110 → lframe_o low 4 clocks with LAD=F, then done_o+err_o; with the macro off, busy_o stays high for 100 clocks.
- Invalid SYNC 4'b0011 → immediate ABORT sequence, err_o=1; a back-to-back req_i in the done_o cycle is accepted, and START appears on the next clock.
- nrst_i asserted during ADDR1 → outputs at reset values asynchronously, no done_o; the next request after release completes normally.

Source files
------------

// File: rtl/lpc_pkg.sv
// -----------------------------------------------------------------------------
// lpc_pkg
// Shared LPC definitions: the host FSM state encoding and the START, CYCTYPE
// and SYNC field codes. lpc_periph will also use these codes.
// No ports (package).
// -----------------------------------------------------------------------------
package lpc_pkg;

   typedef enum logic [4:0] {
      ST_IDLE,
      ST_START,
      ST_CYCTYPE,
      ST_ADDR3,
      ST_ADDR2,
      ST_ADDR1,
      ST_ADDR0,
      ST_WDATA0,
      ST_WDATA1,
      ST_TARH0,
      ST_TARH1,
      ST_SYNC,
      ST_RDATA0,
      ST_RDATA1,
      ST_TARP0,
      ST_TARP1,
      ST_ABORT,
      ST_ABORT_END
   } lpc_state_e;

   // START field
   localparam logic [3:0] START_TPM       = 4'b0101;
   localparam logic [3:0] START_IO        = 4'b0000;

   // CYCTYPE + DIR field
   localparam logic [3:0] CYCTYPE_IO_RD   = 4'b0000;
   localparam logic [3:0] CYCTYPE_IO_WR   = 4'b0010;

   // SYNC field
   localparam logic [3:0] SYNC_READY      = 4'b0000;
   localparam logic [3:0] SYNC_SHORT_WAIT = 4'b0101;
   localparam logic [3:0] SYNC_LONG_WAIT  = 4'b0110;
   localparam logic [3:0] SYNC_ERROR      = 4'b1010;

   // Selects one nibble of a 16-bit address, index 3 = most significant.
   function automatic logic [3:0] addr_nibble(input logic [15:0] addr, input logic [1:0] idx);
      return addr[{idx, 2'b00} +: 4];
   endfunction

endpackage

// File: rtl/lpc_host_if.sv
// -----------------------------------------------------------------------------
// lpc_host_if
// Bundles the request/completion handshake and the LPC bus pins of lpc_host.
//
// Handshake: req_i is sampled on a rising clk edge only while busy_o=0; that
// edge accepts the request and latches req_wr_i/req_addr_i/req_data_i. busy_o
// then stays high until the cycle in which done_o pulses for exactly one clock
// (err_o alongside it). In the done_o cycle busy_o is already low, so a new
// req_i may be presented and is accepted on the following edge.
//
// Signals:
//   req_i, req_wr_i, req_addr_i[15:0], req_data_i[7:0]  request (into host)
//   busy_o, done_o, err_o, rd_data_o[7:0]               completion (from host)
//   lframe_o, lad_o[3:0], lad_oe_o                      LPC drive (from host)
//   lad_i[3:0]                                          sampled LAD (into host)
//   state_dbg                                           host FSM state
// Modports: master = the host (lpc_host), slave = the requester / bus side.
// -----------------------------------------------------------------------------
interface lpc_host_if;
   import lpc_pkg::*;

   logic        req_i;
   logic        req_wr_i;
   logic [15:0] req_addr_i;
   logic [7:0]  req_data_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [7:0]  rd_data_o;
   logic        lframe_o;
   logic [3:0]  lad_o;
   logic        lad_oe_o;
   logic [3:0]  lad_i;
   lpc_state_e  state_dbg;

   modport master (
      input  req_i, req_wr_i, req_addr_i, req_data_i, lad_i,
      output busy_o, done_o, err_o, rd_data_o, lframe_o, lad_o, lad_oe_o, state_dbg
   );

   modport slave (
      output req_i, req_wr_i, req_addr_i, req_data_i, lad_i,
      input  busy_o, done_o, err_o, rd_data_o, lframe_o, lad_o, lad_oe_o, state_dbg
   );

endinterface

// File: rtl/lpc_host.sv
// -----------------------------------------------------------------------------
// lpc_host
// LPC initiator issuing single-byte I/O / TPM read and write cycles. Accepts
// one request at a time, serialises START/CYCTYPE/ADDR/(WDATA)/TAR, handles
// SYNC waits, captures read data and reports completion or error.
//
// Ports:
//   clk_i   LPC clock (LCLK), rising edge
//   nrst_i  asynchronous active-low reset (LRESET#)
//   bus     lpc_host_if.master: request/completion handshake + LAD/LFRAME#
//
// Parameters:
//   START_NIBBLE  START field value (0101 TPM, 0000 I/O)
//   SYNC_TIMEOUT  consecutive wait SYNCs tolerated before abort (>= 1)
//   ABORT_CYCLES  clocks LFRAME# is held low during abort (>= 4)
//
// Build option: define LPC_HOST_TIMEOUT_EN to abort a cycle whose SYNC keeps
// returning wait codes; without it SYNC waits indefinitely.
// -----------------------------------------------------------------------------
module lpc_host
   import lpc_pkg::*;
#(
   parameter logic [3:0] START_NIBBLE = 4'b0101,
   parameter int         SYNC_TIMEOUT = 32,
   parameter int         ABORT_CYCLES = 4
) (
   input  logic           clk_i,
   input  logic           nrst_i,
   lpc_host_if.master     bus
);

   // One counter serves both the SYNC wait count and the ABORT length: the two
   // phases never overlap and it is cleared on every state change.
   localparam int CNT_MAX = (ABORT_CYCLES > SYNC_TIMEOUT) ? ABORT_CYCLES : SYNC_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   lpc_state_e         state_q, state_d;
   logic               wr_q;
   logic [15:0]        addr_q;
   logic [7:0]         data_q;
   logic               err_flag_q;
   logic [7:0]         rd_buf_q;
   logic [7:0]         rd_data_q;
   logic               done_q;
   logic               err_q;
   logic [CNT_W-1:0]   cnt_q;

   logic               lframe;
   logic               lad_oe;
   logic [3:0]         lad;

   // ---------------------------------------------------------------- FSM state
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // ------------------------------------------- FSM next state + LPC drive
   always_comb begin
      state_d = state_q;
      lframe  = 1'b1;
      lad_oe  = 1'b0;
      lad     = 4'hF;
      case (state_q)
         ST_IDLE: begin
            if (bus.req_i) state_d = ST_START;
         end
         ST_START: begin
            lframe  = 1'b0;
            lad_oe  = 1'b1;
            lad     = START_NIBBLE;
            state_d = ST_CYCTYPE;
         end
         ST_CYCTYPE: begin
            lad_oe  = 1'b1;
            lad     = wr_q ? CYCTYPE_IO_WR : CYCTYPE_IO_RD;
            state_d = ST_ADDR3;
         end
         ST_ADDR3: begin
            lad_oe  = 1'b1;
            lad     = addr_nibble(addr_q, 2'd3);
            state_d = ST_ADDR2;
         end
         ST_ADDR2: begin
            lad_oe  = 1'b1;
            lad     = addr_nibble(addr_q, 2'd2);
            state_d = ST_ADDR1;
         end
         ST_ADDR1: begin
            lad_oe  = 1'b1;
            lad     = addr_nibble(addr_q, 2'd1);
            state_d = ST_ADDR0;
         end
         ST_ADDR0: begin
            lad_oe  = 1'b1;
            lad     = addr_nibble(addr_q, 2'd0);
            state_d = wr_q ? ST_WDATA0 : ST_TARH0;
         end
         ST_WDATA0: begin
            lad_oe  = 1'b1;
            lad     = data_q[3:0];
            state_d = ST_WDATA1;
         end
         ST_WDATA1: begin
            lad_oe  = 1'b1;
            lad     = data_q[7:4];
            state_d = ST_TARH0;
         end
         ST_TARH0: begin
            lad_oe  = 1'b1;
            state_d = ST_TARH1;
         end
         ST_TARH1: begin
            state_d = ST_SYNC;
         end
         ST_SYNC: begin
            case (bus.lad_i)
               SYNC_READY, SYNC_ERROR: state_d = wr_q ? ST_TARP0 : ST_RDATA0;
               SYNC_SHORT_WAIT, SYNC_LONG_WAIT: begin
`ifdef LPC_HOST_TIMEOUT_EN
                  // cnt_q counts waits already seen; this sample is one more.
                  if (cnt_q == CNT_W'(SYNC_TIMEOUT)) state_d = ST_ABORT;
`endif
               end
               default: state_d = ST_ABORT;
            endcase
         end
         ST_RDATA0: state_d = ST_RDATA1;
         ST_RDATA1: state_d = ST_TARP0;
         ST_TARP0:  state_d = ST_TARP1;
         ST_TARP1:  state_d = ST_IDLE;
         ST_ABORT: begin
            lframe = 1'b0;
            lad_oe = 1'b1;
            if (cnt_q == CNT_W'(ABORT_CYCLES - 1)) state_d = ST_ABORT_END;
         end
         ST_ABORT_END: state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         wr_q       <= 1'b0;
         addr_q     <= 16'h0000;
         data_q     <= 8'h00;
         err_flag_q <= 1'b0;
         rd_buf_q   <= 8'h00;
         rd_data_q  <= 8'h00;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;

         if (state_d != state_q) begin
            cnt_q <= '0;
`ifdef LPC_HOST_TIMEOUT_EN
         end else if ((state_q == ST_ABORT || state_q == ST_SYNC) &&
                      cnt_q != {CNT_W{1'b1}}) begin
`else
         end else if (state_q == ST_ABORT && cnt_q != {CNT_W{1'b1}}) begin
`endif
            cnt_q <= cnt_q + 1'b1;
         end

         case (state_q)
            ST_IDLE: begin
               if (bus.req_i) begin
                  wr_q       <= bus.req_wr_i;
                  addr_q     <= bus.req_addr_i;
                  data_q     <= bus.req_data_i;
                  err_flag_q <= 1'b0;
               end
            end
            ST_SYNC: begin
               if (bus.lad_i == SYNC_ERROR) err_flag_q <= 1'b1;
            end
            ST_RDATA0: rd_buf_q[3:0] <= bus.lad_i;
            ST_RDATA1: rd_buf_q[7:4] <= bus.lad_i;
            ST_TARP1: begin
               done_q <= 1'b1;
               err_q  <= err_flag_q;
               if (!wr_q) rd_data_q <= rd_buf_q;
            end
            ST_ABORT_END: begin
               done_q <= 1'b1;
               err_q  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.busy_o    = (state_q != ST_IDLE);
   assign bus.done_o    = done_q;
   assign bus.err_o     = err_q;
   assign bus.rd_data_o = rd_data_q;
   assign bus.lframe_o  = lframe;
   assign bus.lad_o     = lad;
   assign bus.lad_oe_o  = lad_oe;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_lpc_host.sv
// -----------------------------------------------------------------------------
// tb_lpc_host
// Bench for lpc_host: a table of transactions with scripted peripheral SYNC /
// data responses, per-clock checks of the host's LPC drive, and a scoreboard
// of expected {err, rd_data, latency} compared at each done_o. Hand-written
// sequences cover reset values, SYNC timeout (or endless wait when the
// timeout is not built) and an asynchronous reset in the middle of a cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lpc_host;

   localparam int TIMEOUT = 4;

   typedef struct {
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  data;
      int          gap;        // idle clocks before the request
      int          n_wait;     // number of wait SYNCs before sync_final
      logic [3:0]  wait_code;
      logic [3:0]  sync_final;
      logic [3:0]  rnib0;
      logic [3:0]  rnib1;
      bit          exp_err;
      logic [7:0]  exp_rd;
      int          exp_lat;    // accept edge to done_o, in clocks
      int          ab_start;   // first period of abort phase, 0 = none
   } txn_t;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   int   checks = 0;
   int   failures = 0;
   logic [16:0] exp_q[$];      // {err, rd_data[7:0], latency[7:0]}
   txn_t tbl[10];

   lpc_host_if bus();

   lpc_host #(
      .START_NIBBLE (4'b0101),
      .SYNC_TIMEOUT (TIMEOUT),
      .ABORT_CYCLES (4)
   ) dut (
      .clk_i  (clk),
      .nrst_i (nrst),
      .bus    (bus)
   );

   // ------------------------------------------------------------ clock/reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------ helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic txn_t mk(input bit wr, input logic [15:0] addr, input logic [7:0] data,
                               input int gap, input int n_wait, input logic [3:0] wait_code,
                               input logic [3:0] sync_final, input logic [3:0] rnib0,
                               input logic [3:0] rnib1, input bit exp_err,
                               input logic [7:0] exp_rd, input int exp_lat, input int ab_start);
      txn_t t;
      t.wr = wr; t.addr = addr; t.data = data; t.gap = gap; t.n_wait = n_wait;
      t.wait_code = wait_code; t.sync_final = sync_final; t.rnib0 = rnib0; t.rnib1 = rnib1;
      t.exp_err = exp_err; t.exp_rd = exp_rd; t.exp_lat = exp_lat; t.ab_start = ab_start;
      return t;
   endfunction

   // Expected {lframe, oe, lad} in header period p (1 = START).
   function automatic logic [5:0] hdr(input txn_t t, input int p);
      logic [5:0] e;
      e = {1'b1, 1'b1, 4'hF};
      case (p)
         1: e = {1'b0, 1'b1, 4'b0101};
         2: e = {1'b1, 1'b1, (t.wr ? 4'b0010 : 4'b0000)};
         3: e = {1'b1, 1'b1, t.addr[15:12]};
         4: e = {1'b1, 1'b1, t.addr[11:8]};
         5: e = {1'b1, 1'b1, t.addr[7:4]};
         6: e = {1'b1, 1'b1, t.addr[3:0]};
         default: begin
            if (t.wr) begin
               if (p == 7)       e = {1'b1, 1'b1, t.data[3:0]};
               else if (p == 8)  e = {1'b1, 1'b1, t.data[7:4]};
               else if (p == 9)  e = {1'b1, 1'b1, 4'hF};
               else              e = {1'b1, 1'b0, 4'hF};
            end else begin
               if (p == 7)       e = {1'b1, 1'b1, 4'hF};
               else              e = {1'b1, 1'b0, 4'hF};
            end
         end
      endcase
      return e;
   endfunction

   // Peripheral's LAD value for period p; ss = first SYNC period.
   function automatic logic [3:0] lad_sched(input txn_t t, input int p, input int ss);
      if (p >= ss && p < ss + t.n_wait)          return t.wait_code;
      if (p == ss + t.n_wait)                    return t.sync_final;
      if (!t.wr && p == ss + t.n_wait + 1)       return t.rnib0;
      if (!t.wr && p == ss + t.n_wait + 2)       return t.rnib1;
      return 4'hF;
   endfunction

   // ------------------------------------------------------------ driver
   // Called on a falling edge; returns on the falling edge where done_o is seen.
   task automatic run_txn(input txn_t t, input string tag);
      int ss;
      bit done_seen;
      logic [5:0] e, a;
      logic [16:0] x;
      repeat (t.gap) @(negedge clk);
      bus.req_i      = 1'b1;
      bus.req_wr_i   = t.wr;
      bus.req_addr_i = t.addr;
      bus.req_data_i = t.data;
      @(posedge clk);
      exp_q.push_back({t.exp_err, t.exp_rd, 8'(t.exp_lat)});
      ss = t.wr ? 11 : 9;
      done_seen = 1'b0;
      for (int p = 1; p <= 200 && !done_seen; p++) begin
         @(negedge clk);
         if (p == 1) begin
            bus.req_i = 1'b0;
            check({tag, " busy"}, 32'(bus.busy_o), 32'd1);
         end
         a = {bus.lframe_o, bus.lad_oe_o, bus.lad_o};
         if (p < ss) begin
            e = hdr(t, p);
            if (e[4]) check($sformatf("%s hdr p%0d", tag, p), 32'(a), 32'(e));
            else      check($sformatf("%s hdr p%0d", tag, p), 32'(a[5:4]), 32'(e[5:4]));
         end
         if (t.ab_start > 0 && p >= t.ab_start && p < t.ab_start + 4)
            check($sformatf("%s abort p%0d", tag, p), 32'(a), 32'h1F);
         if (t.ab_start > 0 && p == t.ab_start + 4)
            check($sformatf("%s abort_end", tag), 32'(a[5:4]), 32'b10);
         if (bus.done_o) begin
            done_seen = 1'b1;
            x = exp_q.pop_front();
            check({tag, " err"},     32'(bus.err_o),     32'(x[16]));
            check({tag, " rd_data"}, 32'(bus.rd_data_o), 32'(x[15:8]));
            check({tag, " latency"}, 32'(p - 1),         32'(x[7:0]));
            check({tag, " busy@done"}, 32'(bus.busy_o),  32'd0);
         end
         bus.lad_i = done_seen ? 4'hF : lad_sched(t, p, ss);
      end
      if (!done_seen) begin
         checks++;
         failures++;
         $display("FAIL %s done: no done_o within 200 clocks", tag);
         void'(exp_q.pop_front());
      end
   endtask

   // ------------------------------------------------------------ stimulus
   initial begin
      int busy_cnt;
      int done_cnt;
      bus.req_i      = 1'b0;
      bus.req_wr_i   = 1'b0;
      bus.req_addr_i = 16'h0000;
      bus.req_data_i = 8'h00;
      bus.lad_i      = 4'hF;

      //            wr    addr      data  gap nw code  fin   n0    n1    err  rd     lat ab
      tbl[0] = mk(1'b1, 16'h0F00, 8'hA5, 2, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'h00, 13, 0);
      tbl[1] = mk(1'b0, 16'h0F18, 8'h00, 1, 3, 4'h6, 4'h0, 4'h3, 4'hC, 1'b0, 8'hC3, 16, 0);
      tbl[2] = mk(1'b0, 16'h1234, 8'h00, 0, 0, 4'h0, 4'hA, 4'h0, 4'h0, 1'b1, 8'h00, 13, 0);
      tbl[3] = mk(1'b0, 16'hABCD, 8'h00, 3, 1, 4'h5, 4'h0, 4'h7, 4'hE, 1'b0, 8'hE7, 14, 0);
      tbl[4] = mk(1'b1, 16'h8001, 8'h3C, 0, 2, 4'h5, 4'hA, 4'h0, 4'h0, 1'b1, 8'hE7, 15, 0);
      tbl[5] = mk(1'b1, 16'h7777, 8'h5A, 1, 2, 4'h6, 4'h0, 4'h0, 4'h0, 1'b0, 8'hE7, 15, 0);
      tbl[6] = mk(1'b0, 16'h0055, 8'h00, 2, 0, 4'h0, 4'h3, 4'h9, 4'h9, 1'b1, 8'hE7, 14, 10);
      tbl[7] = mk(1'b1, 16'h5A5A, 8'hFF, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 8'hE7, 13, 0);
      tbl[8] = mk(1'b0, 16'hFFFF, 8'h00, 0, 2, 4'h5, 4'hC, 4'h1, 4'h1, 1'b1, 8'hE7, 16, 12);
      tbl[9] = mk(1'b0, 16'h0001, 8'h00, 1, 0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 8'h0F, 13, 0);

      // reset values
      repeat (2) @(negedge clk);
      check("rst lframe",  32'(bus.lframe_o),  32'd1);
      check("rst lad",     32'(bus.lad_o),     32'hF);
      check("rst oe",      32'(bus.lad_oe_o),  32'd0);
      check("rst busy",    32'(bus.busy_o),    32'd0);
      check("rst done",    32'(bus.done_o),    32'd0);
      check("rst err",     32'(bus.err_o),     32'd0);
      check("rst rd_data", 32'(bus.rd_data_o), 32'h00);
      nrst = 1'b1;

      // table: entries 0..5 and 7..9 start with their own gap; entry 7 has
      // gap 0, so it is requested in the done_o cycle of the abort before it.
      for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("txn%0d", i));

`ifdef LPC_HOST_TIMEOUT_EN
      // endless LONG_WAIT: 5th wait sample aborts (4 tolerated)
      run_txn(mk(1'b0, 16'h0100, 8'h00, 1, 1000, 4'h6, 4'h0, 4'h0, 4'h0,
                 1'b1, 8'h0F, 18, 14), "timeout");
`else
      // endless LONG_WAIT without timeout: stays busy
      @(negedge clk);
      bus.req_i = 1'b1; bus.req_wr_i = 1'b0; bus.req_addr_i = 16'h0100;
      @(posedge clk);
      busy_cnt = 0;
      done_cnt = 0;
      for (int p = 1; p <= 100; p++) begin
         @(negedge clk);
         bus.req_i = 1'b0;
         if (bus.busy_o) busy_cnt++;
         if (bus.done_o) done_cnt++;
         bus.lad_i = (p >= 9) ? 4'h6 : 4'hF;
      end
      check("hang busy clocks", 32'(busy_cnt), 32'd100);
      check("hang done",        32'(done_cnt), 32'd0);
      nrst = 1'b0;
      @(negedge clk);
      bus.lad_i = 4'hF;
      nrst = 1'b1;
`endif

      // asynchronous reset during ADDR1
      @(negedge clk);
      bus.req_i = 1'b1; bus.req_wr_i = 1'b1; bus.req_addr_i = 16'h1234; bus.req_data_i = 8'h55;
      @(posedge clk);
      for (int p = 1; p <= 5; p++) begin
         @(negedge clk);
         bus.req_i = 1'b0;
      end
      check("pre-rst ADDR1 lad", 32'(bus.lad_o), 32'h3);
      #2 nrst = 1'b0;
      #1;
      check("async rst lframe",  32'(bus.lframe_o),  32'd1);
      check("async rst oe",      32'(bus.lad_oe_o),  32'd0);
      check("async rst lad",     32'(bus.lad_o),     32'hF);
      check("async rst busy",    32'(bus.busy_o),    32'd0);
      check("async rst rd_data", 32'(bus.rd_data_o), 32'h00);
      done_cnt = 0;
      for (int p = 0; p < 3; p++) begin
         @(negedge clk);
         if (bus.done_o || bus.err_o) done_cnt++;
      end
      check("async rst no done", 32'(done_cnt), 32'd0);
      nrst = 1'b1;
      run_txn(mk(1'b0, 16'h0F18, 8'h00, 1, 0, 4'h0, 4'h0, 4'hA, 4'h5,
                 1'b0, 8'h5A, 13, 0), "post_rst");

      check("scoreboard empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
